// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial add/subtract engine.
// The master drives the request; the slave (the engine) returns status and results.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract engine: one full-adder cell plus a carry flop,
// processing one operand bit per clock LSB first, results latched on entry to DONE.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] ps_q, ps_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_s, fa_co, last_bit, c_msb_in;

  always_comb begin
    fa_s     = sa_q[0] ^ sb_q[0] ^ c_q;
    fa_co    = (sa_q[0] & sb_q[0]) | (c_q & (sa_q[0] ^ sb_q[0]));
    last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    // Carry into the MSB cell is the carry register while the last bit is processed.
    c_msb_in = c_q;

    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ps_d    = ps_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sa_d    = bus.a;
          // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
          sb_d    = bus.sub ? ~bus.b : bus.b;
          c_d     = bus.sub;
          cnt_d   = '0;
          ps_d    = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        ps_d  = {fa_s, ps_q[WIDTH-1:1]};
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        c_d   = fa_co;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_bit) begin
          sum_d   = {fa_s, ps_q[WIDTH-1:1]};
          cout_d  = fa_co;
          ovf_d   = c_msb_in ^ fa_co;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      ps_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ps_q    <= ps_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases, start-while-busy,
// mid-run async reset, held start, and random operands against an arithmetic model.
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: unsigned/signed integer arithmetic, returns {cout, ovf, sum}.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                             input logic rsub);
    longint lim, ua, ub, sa, sb, r, sr;
    logic   c, o;
    logic [W-1:0] s;
    lim = longint'(1) << W;
    ua  = longint'(ra);
    ub  = longint'(rb);
    sa  = ra[W-1] ? ua - lim : ua;
    sb  = rb[W-1] ? ub - lim : ub;
    if (!rsub) begin
      r  = ua + ub;
      c  = (r >= lim);
      sr = sa + sb;
    end else begin
      r  = ua - ub;
      c  = (ua >= ub);
      sr = sa - sb;
    end
    s = W'(r);
    o = (sr > (lim / 2) - 1) || (sr < -(lim / 2));
    return {c, o, s};
  endfunction

  // Issues one start and waits (bounded) for done; outputs are sampled at the done cycle.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                       output int lat, output int bcnt, output int both);
    @(negedge clk);
    bus.start = 1'b1; bus.a = ta; bus.b = tb_; bus.sub = ts;
    @(negedge clk);
    bus.start = 1'b0; bus.a = W'($urandom); bus.b = W'($urandom); bus.sub = 1'($urandom);
    lat = 1; bcnt = 0; both = 0;
    while (bus.done !== 1'b1 && lat < 4 * W) begin
      if (bus.busy === 1'b1) bcnt++;
      if (bus.busy === 1'b1 && bus.done === 1'b1) both++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%0d cout=%b ovf=%b, expected all 0",
               bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got busy=%b done=%b, expected 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [5] = '{8'd100, 8'd200, 8'd100, 8'd5,   8'h80};
    logic [W-1:0] tb_[5] = '{8'd27,  8'd100, 8'd50,  8'd7,   8'h01};
    logic         ts [5] = '{1'b0,   1'b0,   1'b0,   1'b1,   1'b1};
    logic [W-1:0] es [5] = '{8'd127, 8'd44,  8'd150, 8'd254, 8'h7F};
    logic         ec [5] = '{1'b0,   1'b1,   1'b0,   1'b0,   1'b1};
    logic         eo [5] = '{1'b0,   1'b0,   1'b1,   1'b0,   1'b1};
    int lat, bcnt, both;
    for (int i = 0; i < 5; i++) begin
      do_op(ta[i], tb_[i], ts[i], lat, bcnt, both);
      vectors++;
      if ({bus.sum, bus.cout, bus.ovf} !== {es[i], ec[i], eo[i]}) begin
        miscompares++;
        $display("FAIL directed_%0d: got sum=%0d cout=%b ovf=%b, expected sum=%0d cout=%b ovf=%b",
                 i, bus.sum, bus.cout, bus.ovf, es[i], ec[i], eo[i]);
      end
      vectors++;
      if (lat != W + 1 || bcnt != W || both != 0) begin
        miscompares++;
        $display("FAIL directed_timing_%0d: got latency=%0d busy_cycles=%0d overlap=%0d, expected %0d %0d 0",
                 i, lat, bcnt, both, W + 1, W);
      end
    end
  endtask

  task automatic test_ignore_start();
    int n, dones;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'd100; bus.b = 8'd27; bus.sub = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.a = 8'd1; bus.b = 8'd1; bus.sub = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (bus.done !== 1'b1 && n < 4 * W) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.done !== 1'b1 || bus.sum !== 8'd127) begin
      miscompares++;
      $display("FAIL ignore_start_result: got done=%b sum=%0d, expected 1 127", bus.done, bus.sum);
    end
    dones = 0;
    repeat (2 * W) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0 || bus.sum !== 8'd127 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_start_extra: got extra_done=%0d sum=%0d busy=%b, expected 0 127 0",
               dones, bus.sum, bus.busy);
    end
  endtask

  task automatic test_async_reset();
    int dones, lat, bcnt, both;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'd200; bus.b = 8'd100; bus.sub = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.busy, bus.done, bus.sum, bus.cout, bus.ovf} !== '0) begin
      miscompares++;
      $display("FAIL async_reset_clear: got busy=%b done=%b sum=%0d cout=%b ovf=%b, expected all 0",
               bus.busy, bus.done, bus.sum, bus.cout, bus.ovf);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (2 * W) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL async_reset_resume: got %0d active cycles after reset, expected 0", dones);
    end
    do_op(8'd10, 8'd20, 1'b0, lat, bcnt, both);
    vectors++;
    if (bus.sum !== 8'd30 || lat != W + 1) begin
      miscompares++;
      $display("FAIL async_reset_fresh_op: got sum=%0d latency=%0d, expected 30 %0d",
               bus.sum, lat, W + 1);
    end
  endtask

  task automatic test_back_to_back();
    int pos[$];
    int both;
    logic [W+1:0] exp;
    exp = ref_model(8'd55, 8'd77, 1'b1);
    both = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'd55; bus.b = 8'd77; bus.sub = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b1 && bus.done === 1'b1) both++;
      if (bus.done === 1'b1) begin
        pos.push_back(i);
        vectors++;
        if ({bus.cout, bus.ovf, bus.sum} !== exp) begin
          miscompares++;
          $display("FAIL b2b_result: got %h, expected %h", {bus.cout, bus.ovf, bus.sum}, exp);
        end
      end
    end
    bus.start = 1'b0;
    vectors++;
    if (pos.size() != 3 || both != 0) begin
      miscompares++;
      $display("FAIL b2b_count: got pulses=%0d overlap=%0d, expected 3 0", pos.size(), both);
    end
    for (int i = 1; i < pos.size(); i++) begin
      vectors++;
      if (pos[i] - pos[i-1] != W + 2) begin
        miscompares++;
        $display("FAIL b2b_spacing: got %0d, expected %0d", pos[i] - pos[i-1], W + 2);
      end
    end
    repeat (2 * W) @(negedge clk);
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic         rs;
    logic [W+1:0] exp;
    int lat, bcnt, both;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      if (i < 4) begin
        ra = (i[0]) ? 8'h7F : 8'h80;
        rb = (i[1]) ? 8'hFF : 8'h80;
      end
      exp = ref_model(ra, rb, rs);
      do_op(ra, rb, rs, lat, bcnt, both);
      vectors++;
      if ({bus.cout, bus.ovf, bus.sum} !== exp || lat != W + 1 || both != 0) begin
        miscompares++;
        $display("FAIL random_%0d: a=%0d b=%0d sub=%b got cout=%b ovf=%b sum=%0d lat=%0d, expected cout=%b ovf=%b sum=%0d lat=%0d",
                 i, ra, rb, rs, bus.cout, bus.ovf, bus.sum, lat, exp[W+1], exp[W], exp[W-1:0], W + 1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
